// File: rtl/pipe_ctrl_unit.sv
// Pipelined RV32I main controller: decodes the D-stage opcode, carries the control
// bundle through E/M/W with flush/stall bubbles, and resolves branches and jumps in E.
module pipe_ctrl_unit #(
  parameter int unsigned ALUCTRL_W = 3,
  parameter bit          EN_JALR   = 1'b1,
  parameter bit          EN_LUI    = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opD,
  input  logic [2:0]           funct3D,
  input  logic                 funct7b5D,
  input  logic                 FlushE,
  input  logic                 StallE,
  input  logic                 ZeroE,
  input  logic                 LtE,
  input  logic                 LtuE,
  output logic [2:0]           ImmSrcD,
  output logic                 IllegalD,
  output logic                 RegWriteE,
  output logic                 RegWriteM,
  output logic                 RegWriteW,
  output logic [1:0]           ResultSrcE,
  output logic [1:0]           ResultSrcM,
  output logic [1:0]           ResultSrcW,
  output logic                 MemWriteE,
  output logic                 MemWriteM,
  output logic                 ALUSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 JalrE,
  output logic                 PCSrcE,
  output logic                 IllegalE
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  // alt selects sub (funct3=000) or sra (funct3=101)
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  logic       reg_write_d, mem_write_d, branch_d, jump_d, jalr_d, alu_src_d, arith_d;
  logic [1:0] result_src_d;
  logic [3:0] alu_code_d;
  logic       wide_op_d;
  logic       jump_e_reg, branch_e_reg, branch_cond;
  logic [2:0] funct3_e_reg;

  always_comb begin
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    branch_d     = 1'b0;
    jump_d       = 1'b0;
    jalr_d       = 1'b0;
    alu_src_d    = 1'b0;
    arith_d      = 1'b0;
    result_src_d = 2'b00;
    alu_code_d   = ALU_ADD;
    ImmSrcD      = 3'b000;
    IllegalD     = 1'b0;
    case (opD)
      OP_LW: begin
        reg_write_d  = 1'b1;
        result_src_d = 2'b01;
        alu_src_d    = 1'b1;
      end
      OP_SW: begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
        ImmSrcD     = 3'b001;
      end
      OP_R: begin
        reg_write_d = 1'b1;
        arith_d     = 1'b1;
        alu_code_d  = alu_op(funct3D, funct7b5D);
      end
      OP_I: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        arith_d     = 1'b1;
        alu_code_d  = alu_op(funct3D, funct7b5D & (funct3D == 3'b101));
      end
      OP_B: begin
        branch_d   = 1'b1;
        alu_code_d = ALU_SUB;
        ImmSrcD    = 3'b010;
        IllegalD   = (funct3D == 3'b010) || (funct3D == 3'b011);
      end
      OP_JAL: begin
        reg_write_d  = 1'b1;
        jump_d       = 1'b1;
        result_src_d = 2'b10;
        ImmSrcD      = 3'b011;
      end
      OP_JALR: begin
        reg_write_d  = 1'b1;
        jump_d       = 1'b1;
        jalr_d       = 1'b1;
        alu_src_d    = 1'b1;
        result_src_d = 2'b10;
        IllegalD     = !EN_JALR;
      end
      OP_LUI: begin
        reg_write_d  = 1'b1;
        result_src_d = 2'b11;
        ImmSrcD      = 3'b100;
        IllegalD     = !EN_LUI;
      end
      default: IllegalD = 1'b1;
    endcase
    // A narrow ALU cannot execute xor/sltu/shifts
    wide_op_d = (alu_code_d == ALU_XOR) || (alu_code_d == ALU_SLTU) || (alu_code_d == ALU_SLL) ||
                (alu_code_d == ALU_SRL) || (alu_code_d == ALU_SRA);
    if (arith_d && wide_op_d && (ALUCTRL_W < 4))
      IllegalD = 1'b1;
  end

  // E register: reset/flush load a bubble, stall holds, otherwise capture gated decode
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      RegWriteE    <= 1'b0;
      ResultSrcE   <= 2'b00;
      MemWriteE    <= 1'b0;
      ALUSrcE      <= 1'b0;
      ALUControlE  <= '0;
      JalrE        <= 1'b0;
      jump_e_reg   <= 1'b0;
      branch_e_reg <= 1'b0;
      funct3_e_reg <= 3'b000;
      IllegalE     <= 1'b0;
    end else if (!StallE) begin
      RegWriteE    <= reg_write_d & !IllegalD;
      ResultSrcE   <= IllegalD ? 2'b00 : result_src_d;
      MemWriteE    <= mem_write_d & !IllegalD;
      ALUSrcE      <= alu_src_d & !IllegalD;
      ALUControlE  <= IllegalD ? '0 : alu_code_d[ALUCTRL_W-1:0];
      JalrE        <= jalr_d & !IllegalD;
      jump_e_reg   <= jump_d & !IllegalD;
      branch_e_reg <= branch_d & !IllegalD;
      funct3_e_reg <= funct3D;
      IllegalE     <= IllegalD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || StallE) begin
      RegWriteM  <= 1'b0;
      ResultSrcM <= 2'b00;
      MemWriteM  <= 1'b0;
    end else begin
      RegWriteM  <= RegWriteE;
      ResultSrcM <= ResultSrcE;
      MemWriteM  <= MemWriteE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
    end else begin
      RegWriteW  <= RegWriteM;
      ResultSrcW <= ResultSrcM;
    end
  end

  always_comb begin
    case (funct3_e_reg)
      3'b000:  branch_cond = ZeroE;
      3'b001:  branch_cond = !ZeroE;
      3'b100:  branch_cond = LtE;
      3'b101:  branch_cond = !LtE;
      3'b110:  branch_cond = LtuE;
      3'b111:  branch_cond = !LtuE;
      default: branch_cond = 1'b0;
    endcase
  end

  assign PCSrcE = !reset && (jump_e_reg || (branch_e_reg && branch_cond));

endmodule
